// File: rtl/cla_pkg.sv
// Shared constants, group propagate/generate pair and depth helper for the
// pipelined carry-lookahead adder.
package cla_pkg;

    localparam int GRP_W = 4;

    typedef struct packed {
        logic p;
        logic g;
    } pg_t;

    function automatic int nseg(input int width, input int seg_w);
        return width / seg_w;
    endfunction

endpackage

// File: rtl/cla_grp4.sv
// 4-bit carry-lookahead group: internal carries fully expanded, plus group
// propagate/generate for the next lookahead level.
module cla_grp4
    import cla_pkg::*;
(
    input  logic [GRP_W-1:0] a,
    input  logic [GRP_W-1:0] b,
    input  logic             ci,
    output logic [GRP_W-1:0] s,
    output logic             pg,
    output logic             gg
);

    logic [GRP_W-1:0] w_p;
    logic [GRP_W-1:0] w_g;
    logic [GRP_W-1:0] w_c;

    assign w_p = a ^ b;
    assign w_g = a & b;

    assign w_c[0] = ci;
    assign w_c[1] = w_g[0] | (w_p[0] & ci);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & ci);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & ci);

    assign s  = w_p ^ w_c;
    assign pg = &w_p;
    assign gg = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
              | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined CLA adder/subtractor: one SEG_W-bit segment resolved per stage,
// carry registered between stages, valid/ready with a single global advance.
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SEG_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NSEG = nseg(WIDTH, SEG_W);
    localparam int NGRP = SEG_W / GRP_W;

    if ((WIDTH % SEG_W) != 0 || (SEG_W % GRP_W) != 0) begin : g_param_chk
        $error("cla_pipe_adder: WIDTH must be a multiple of SEG_W, SEG_W a multiple of 4");
    end

    logic             w_adv;
    logic [WIDTH-1:0] w_bx;
    logic             w_c0;

    assign w_bx     = sub ? ~b : b;
    assign w_c0     = sub | cin;
    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;

    for (genvar k = 0; k < NSEG; k++) begin : g_stg
        localparam int LO = k * SEG_W;
        localparam int HI = LO + SEG_W;

        // Operand bits not yet consumed, this segment in the low SEG_W bits.
        logic [WIDTH-LO-1:0] w_ain, w_bin;
        logic [SEG_W-1:0]    w_a, w_b, w_s;
        logic                w_ci, w_vin;
        logic [HI-1:0]       w_sum;
        pg_t  [NGRP-1:0]     w_pg;
        logic [NGRP:0]       w_gc;
        logic [HI-1:0]       r_sum;
        logic                r_co, r_vld;

        if (k == 0) begin : g_first
            assign w_ain = a;
            assign w_bin = w_bx;
            assign w_ci  = w_c0;
            assign w_vin = in_valid;
            assign w_sum = w_s;
        end else begin : g_next
            assign w_ain = g_stg[k-1].g_op.r_a;
            assign w_bin = g_stg[k-1].g_op.r_b;
            assign w_ci  = g_stg[k-1].r_co;
            assign w_vin = g_stg[k-1].r_vld;
            assign w_sum = {w_s, g_stg[k-1].r_sum};
        end

        assign w_a = w_ain[SEG_W-1:0];
        assign w_b = w_bin[SEG_W-1:0];

        for (genvar j = 0; j < NGRP; j++) begin : g_grp
            cla_grp4 u_grp (
                .a  (w_a[j*GRP_W +: GRP_W]),
                .b  (w_b[j*GRP_W +: GRP_W]),
                .ci (w_gc[j]),
                .s  (w_s[j*GRP_W +: GRP_W]),
                .pg (w_pg[j].p),
                .gg (w_pg[j].g)
            );
        end

        // Each group carry is a flat sum-of-products over the group P/G terms.
        always_comb begin : p_la
            logic t;
            t    = 1'b0;
            w_gc = '0;
            for (int j = 0; j <= NGRP; j++) begin
                t = w_ci;
                for (int m = 0; m < j; m++) t = t & w_pg[m].p;
                w_gc[j] = t;
                for (int i = 0; i < j; i++) begin
                    t = w_pg[i].g;
                    for (int m = i + 1; m < j; m++) t = t & w_pg[m].p;
                    w_gc[j] = w_gc[j] | t;
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_sum <= '0;
                r_co  <= 1'b0;
                r_vld <= 1'b0;
            end else if (w_adv) begin
                r_sum <= w_sum;
                r_co  <= w_gc[NGRP];
                r_vld <= w_vin;
            end
        end

        if (k < NSEG - 1) begin : g_op
            logic [WIDTH-HI-1:0] r_a, r_b;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_adv) begin
                    r_a <= w_ain[WIDTH-LO-1:SEG_W];
                    r_b <= w_bin[WIDTH-LO-1:SEG_W];
                end
            end
        end else begin : g_last
            logic r_ovf, r_zero;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_ovf  <= 1'b0;
                    r_zero <= 1'b0;
                end else if (w_adv) begin
                    r_ovf  <= (w_a[SEG_W-1] == w_b[SEG_W-1]) && (w_s[SEG_W-1] != w_a[SEG_W-1]);
                    r_zero <= (w_sum == '0);
                end
            end
        end
    end

    assign out_valid = g_stg[NSEG-1].r_vld;
    assign sum       = g_stg[NSEG-1].r_sum;
    assign cout      = g_stg[NSEG-1].r_co;
    assign ovf       = g_stg[NSEG-1].g_last.r_ovf;
    assign zero      = g_stg[NSEG-1].g_last.r_zero;

endmodule
